mrr_loopback_pop_arbiter: RTL and testbench
===========================================

Name: mrr_loopback_pop_arbiter

Overview:
Shares the single pop port of the per-node loopback queue between NUM_DECODE_CHAINS decode chains. It uses rotating-priority arbitration and a four-phase request/ack handshake toward each chain. It sequences one queue pop transaction at a time and bounds every transaction with a timeout. It sits between the decode chains and the loopback queue inside the MRR gateway.

Parameters:
NUM_DECODE_CHAINS, 4, number of requesting decode chains
CHIP_ID_LEN, 8, chip ID width
LOOPBACK_MESSAGE_LEN, 32, loopback message width
TIMEOUT_CYCLES, 4000, maximum number of cycles to wait for the queue ack; must be at least 2
TIMEOUT_LEN, 12, width of the timeout counter; must satisfy 2^TIMEOUT_LEN > TIMEOUT_CYCLES

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
pop_request  input  NUM_DECODE_CHAINS  per-chain pop request; held until acked
pop_chip_id  input  NUM_DECODE_CHAINS*CHIP_ID_LEN  per-chain chip ID; chain i at bits [(i+1)*CHIP_ID_LEN-1 -: CHIP_ID_LEN]
pop_ack  output  NUM_DECODE_CHAINS  per-chain ack, one-hot or zero
pop_valid  output  1  1 = pop_message holds a message for the acked chain; 0 = no message or timeout
pop_message  output  LOOPBACK_MESSAGE_LEN  returned message; broadcast to all chains
q_pop_request  output  1  request to the loopback queue
q_pop_chip_id  output  CHIP_ID_LEN  chip ID forwarded to the queue
q_pop_ack  input  1  queue completion pulse
q_pop_valid  input  1  queue found a matching message; sampled with q_pop_ack
q_pop_message  input  LOOPBACK_MESSAGE_LEN  queue message; sampled with q_pop_ack
busy  output  1  high whenever the state is not IDLE
timeout_count  output  16  saturating count of timed-out transactions

Behaviour:
- All outputs are registered. On reset: every output is 0, the state is IDLE, rr_ptr = 0, grant_idx = 0, the timer is 0 and timeout_count is 0.
- Reset asserted in any state aborts the transaction immediately; no ack is issued. The queue is expected to be reset together with this block.
- There are three states: IDLE, ISSUE and RESPOND.
- IDLE:
  - The arbiter searches pop_request for the first set bit, starting at index rr_ptr and scanning upward with wrap-around.
  - On a hit, it latches grant_idx and loads q_pop_chip_id from that chain's ID.
  - It sets q_pop_request = 1, clears the timer and moves to ISSUE.
  - q_pop_request is therefore high 1 cycle after pop_request is seen.
- ISSUE:
  - q_pop_request and q_pop_chip_id stay stable; the timer increments every cycle.
  - If q_pop_ack = 1: capture pop_valid <= q_pop_valid and pop_message <= q_pop_message, clear q_pop_request, set pop_ack[grant_idx] = 1, and move to RESPOND.
  - Else, if the timer = TIMEOUT_CYCLES-1: clear q_pop_request, set pop_valid = 0, leave pop_message unchanged, increment timeout_count (saturating at 16'hFFFF), set pop_ack[grant_idx] = 1, and move to RESPOND.
  - q_pop_ack arriving in the same cycle as the timeout terminal value counts as an ack, not a timeout.
- RESPOND:
  - pop_ack[grant_idx] is held high until pop_request[grant_idx] is sampled low.
  - In that cycle: clear pop_ack, set rr_ptr <= (grant_idx+1) mod NUM_DECODE_CHAINS, and move to IDLE.
  - pop_valid and pop_message hold their values until the next capture.
- Mid-transaction drop: if the granted chain drops its request during ISSUE, the queue transaction still completes. RESPOND then sees the request low on its first cycle, so pop_ack is high for exactly 1 cycle.
- q_pop_ack seen in IDLE or RESPOND (a late ack after a timeout) is ignored and has no side effects.
- Requests from other chains arriving during ISSUE or RESPOND wait; there is no preemption.
- A new arbitration may start in the cycle after a return to IDLE. The minimum transaction is therefore 4 cycles: IDLE grant, ISSUE ack, RESPOND release, IDLE.
- Fairness: a chain that is continuously requesting is granted within NUM_DECODE_CHAINS transactions.
- The timer is TIMEOUT_LEN bits wide and is compared for equality only.

Test Plan:
- Single chain: pop_request = 4'b0100, chip 2 ID 8'h5A; queue acks 3 cycles after q_pop_request with q_pop_valid = 1 and message 32'hDEADBEEF -> q_pop_chip_id = 8'h5A; pop_ack = 4'b0100 with pop_valid = 1 and pop_message = 32'hDEADBEEF; ack held until the request drops; rr_ptr becomes 3.
- Round robin: pop_request = 4'b1111 held high and re-raised after each ack, queue acks in 1 cycle -> grant order 0, 1, 2, 3, 0; never two pop_ack bits high at once.
- Timeout: TIMEOUT_CYCLES = 8, queue never acks -> q_pop_request drops after 8 cycles in ISSUE; pop_ack pulses with pop_valid = 0; timeout_count = 1; a late q_pop_ack 2 cycles later causes no change.
- Empty result: queue acks with q_pop_valid = 0 -> pop_ack is asserted with pop_valid = 0; timeout_count is unchanged.
- Abort: chain 1 drops its request 1 cycle into ISSUE, queue acks later -> pop_ack[1] is a 1-cycle pulse; state returns to IDLE; chain 3 requesting is granted next.
- Reset mid-ISSUE: assert rst while q_pop_request = 1 -> the next cycle shows all outputs 0, busy = 0 and no pop_ack; after reset a request to chain 0 is granted first (rr_ptr = 0).

Source files
------------

// File: rtl/mrr_loopback_pop_arbiter.sv
// Shares the loopback queue pop port among decode chains with rotating priority.
// Grant 1 cycle after request; ack held until the chain drops its request; one timed transaction at a time.
module mrr_loopback_pop_arbiter #(
    parameter int NUM_DECODE_CHAINS    = 4,
    parameter int CHIP_ID_LEN          = 8,
    parameter int LOOPBACK_MESSAGE_LEN = 32,
    parameter int TIMEOUT_CYCLES       = 4000,
    parameter int TIMEOUT_LEN          = 12
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_DECODE_CHAINS-1:0]              pop_request,
    input  logic [NUM_DECODE_CHAINS*CHIP_ID_LEN-1:0]  pop_chip_id,
    output logic [NUM_DECODE_CHAINS-1:0]              pop_ack,
    output logic                                      pop_valid,
    output logic [LOOPBACK_MESSAGE_LEN-1:0]           pop_message,
    output logic                                      q_pop_request,
    output logic [CHIP_ID_LEN-1:0]                    q_pop_chip_id,
    input  logic                                      q_pop_ack,
    input  logic                                      q_pop_valid,
    input  logic [LOOPBACK_MESSAGE_LEN-1:0]           q_pop_message,
    output logic                                      busy,
    output logic [15:0]                               timeout_count
);

    localparam int IDX_W = (NUM_DECODE_CHAINS > 1) ? $clog2(NUM_DECODE_CHAINS) : 1;
    localparam int unsigned NUM_U = NUM_DECODE_CHAINS;
    localparam logic [NUM_DECODE_CHAINS-1:0] ACK_ONE = NUM_DECODE_CHAINS'(1);
    localparam logic [TIMEOUT_LEN-1:0] TIMER_LAST = TIMEOUT_LEN'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;

    state_t                            state_q;
    logic [IDX_W-1:0]                  rr_ptr_q;
    logic [IDX_W-1:0]                  grant_idx_q;
    logic [TIMEOUT_LEN-1:0]            timer_q;
    logic [NUM_DECODE_CHAINS-1:0]      pop_ack_q;
    logic                              pop_valid_q;
    logic [LOOPBACK_MESSAGE_LEN-1:0]   pop_message_q;
    logic                              q_pop_request_q;
    logic [CHIP_ID_LEN-1:0]            q_pop_chip_id_q;
    logic                              busy_q;
    logic [15:0]                       timeout_count_q;

    logic                              pick_hit_d;
    logic [IDX_W-1:0]                  pick_idx_d;

    function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
        return IDX_W'(v % NUM_U);
    endfunction

    // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        pick_hit_d = 1'b0;
        pick_idx_d = '0;
        for (int k = NUM_DECODE_CHAINS - 1; k >= 0; k--) begin
            if (pop_request[wrap_idx(32'(rr_ptr_q) + 32'(k))]) begin
                pick_hit_d = 1'b1;
                pick_idx_d = wrap_idx(32'(rr_ptr_q) + 32'(k));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            rr_ptr_q        <= '0;
            grant_idx_q     <= '0;
            timer_q         <= '0;
            pop_ack_q       <= '0;
            pop_valid_q     <= 1'b0;
            pop_message_q   <= '0;
            q_pop_request_q <= 1'b0;
            q_pop_chip_id_q <= '0;
            busy_q          <= 1'b0;
            timeout_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_hit_d) begin
                        grant_idx_q     <= pick_idx_d;
                        q_pop_chip_id_q <= pop_chip_id[pick_idx_d*CHIP_ID_LEN +: CHIP_ID_LEN];
                        q_pop_request_q <= 1'b1;
                        timer_q         <= '0;
                        busy_q          <= 1'b1;
                        state_q         <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_q <= timer_q + TIMEOUT_LEN'(1);
                    // An ack on the terminal timer cycle wins over the timeout.
                    if (q_pop_ack) begin
                        pop_valid_q     <= q_pop_valid;
                        pop_message_q   <= q_pop_message;
                        q_pop_request_q <= 1'b0;
                        pop_ack_q       <= ACK_ONE << grant_idx_q;
                        state_q         <= RESPOND;
                    end else if (timer_q == TIMER_LAST) begin
                        pop_valid_q     <= 1'b0;
                        q_pop_request_q <= 1'b0;
                        pop_ack_q       <= ACK_ONE << grant_idx_q;
                        if (timeout_count_q != 16'hFFFF) begin
                            timeout_count_q <= timeout_count_q + 16'd1;
                        end
                        state_q         <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (!pop_request[grant_idx_q]) begin
                        pop_ack_q <= '0;
                        rr_ptr_q  <= wrap_idx(32'(grant_idx_q) + 32'd1);
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pop_ack       = pop_ack_q;
    assign pop_valid     = pop_valid_q;
    assign pop_message   = pop_message_q;
    assign q_pop_request = q_pop_request_q;
    assign q_pop_chip_id = q_pop_chip_id_q;
    assign busy          = busy_q;
    assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_mrr_loopback_pop_arbiter.sv
// Bench for mrr_loopback_pop_arbiter: directed vector table, corner-case sequences,
// then randomized chains and queue checked against a transaction-level model.
module tb_mrr_loopback_pop_arbiter;

    localparam int N = 4;
    localparam int T = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   pop_request;
    logic [31:0]  pop_chip_id;
    logic [3:0]   pop_ack;
    logic         pop_valid;
    logic [31:0]  pop_message;
    logic         q_pop_request;
    logic [7:0]   q_pop_chip_id;
    logic         q_pop_ack;
    logic         q_pop_valid;
    logic [31:0]  q_pop_message;
    logic         busy;
    logic [15:0]  timeout_count;

    int n_checks = 0;
    int n_errors = 0;

    mrr_loopback_pop_arbiter #(
        .NUM_DECODE_CHAINS(N), .CHIP_ID_LEN(8), .LOOPBACK_MESSAGE_LEN(32),
        .TIMEOUT_CYCLES(T), .TIMEOUT_LEN(4)
    ) dut (
        .clk(clk), .rst(rst),
        .pop_request(pop_request), .pop_chip_id(pop_chip_id),
        .pop_ack(pop_ack), .pop_valid(pop_valid), .pop_message(pop_message),
        .q_pop_request(q_pop_request), .q_pop_chip_id(q_pop_chip_id),
        .q_pop_ack(q_pop_ack), .q_pop_valid(q_pop_valid), .q_pop_message(q_pop_message),
        .busy(busy), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        qack;
        logic        qvalid;
        logic [31:0] qmsg;
        logic [3:0]  e_ack;
        logic        e_qreq;
        logic [7:0]  e_id;
        logic        e_valid;
        logic [31:0] e_msg;
        logic        e_busy;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; pop_request = '0; q_pop_ack = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    function automatic vec_t mkv(input logic r, input logic [3:0] req, input logic qa, input logic qv,
                                 input logic [31:0] qm, input logic [3:0] ea, input logic eq,
                                 input logic [7:0] ei, input logic ev, input logic [31:0] em,
                                 input logic eb);
        vec_t v;
        v.rst = r; v.req = req; v.qack = qa; v.qvalid = qv; v.qmsg = qm;
        v.e_ack = ea; v.e_qreq = eq; v.e_id = ei; v.e_valid = ev; v.e_msg = em; v.e_busy = eb;
        return v;
    endfunction

    // Round-robin rule: first requester at or after the pointer, wrapping.
    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int j = 0; j < N; j++) begin
            if (r[(p + j) % N]) return (p + j) % N;
        end
        return -1;
    endfunction

    // transaction-level model state for the random phase
    int          ptr, g, qcnt, k, end_len;
    bit          in_tx, hold;
    logic        resp_valid, exp_valid;
    logic [31:0] resp_msg, exp_msg;
    logic [15:0] tcount;
    logic [3:0]  req_a;
    logic [31:0] id_a;

    initial begin
        int n;
        bit ok;
        rst = 1'b1; pop_request = '0; q_pop_ack = 1'b0; q_pop_valid = 1'b0; q_pop_message = '0;
        pop_chip_id = {8'h44, 8'h5A, 8'h22, 8'h11};

        //          rst  req    qa qv qmsg           e_ack  eq e_id   ev e_msg          eb
        vt[0]  = mkv(1, 4'h0, 0, 0, 32'h0,        4'h0, 0, 8'h00, 0, 32'h0,        0);
        vt[1]  = mkv(0, 4'h4, 0, 0, 32'h0,        4'h0, 1, 8'h5A, 0, 32'h0,        1);
        vt[2]  = mkv(0, 4'h4, 0, 0, 32'h0,        4'h0, 1, 8'h5A, 0, 32'h0,        1);
        vt[3]  = mkv(0, 4'h4, 0, 0, 32'h0,        4'h0, 1, 8'h5A, 0, 32'h0,        1);
        vt[4]  = mkv(0, 4'h4, 1, 1, 32'hDEADBEEF, 4'h4, 0, 8'h00, 1, 32'hDEADBEEF, 1);
        vt[5]  = mkv(0, 4'h4, 0, 0, 32'h0,        4'h4, 0, 8'h00, 1, 32'hDEADBEEF, 1);
        vt[6]  = mkv(0, 4'h0, 0, 0, 32'h0,        4'h0, 0, 8'h00, 1, 32'hDEADBEEF, 0);
        vt[7]  = mkv(0, 4'h9, 0, 0, 32'h0,        4'h0, 1, 8'h44, 1, 32'hDEADBEEF, 1);
        vt[8]  = mkv(0, 4'h9, 1, 0, 32'h12345678, 4'h8, 0, 8'h00, 0, 32'h12345678, 1);
        vt[9]  = mkv(0, 4'h1, 0, 0, 32'h0,        4'h0, 0, 8'h00, 0, 32'h12345678, 0);
        vt[10] = mkv(0, 4'h1, 0, 0, 32'h0,        4'h0, 1, 8'h11, 0, 32'h12345678, 1);
        vt[11] = mkv(0, 4'h1, 1, 1, 32'hCAFEF00D, 4'h1, 0, 8'h00, 1, 32'hCAFEF00D, 1);
        vt[12] = mkv(0, 4'h0, 0, 0, 32'h0,        4'h0, 0, 8'h00, 1, 32'hCAFEF00D, 0);

        for (int i = 0; i < 13; i++) begin
            rst = vt[i].rst; pop_request = vt[i].req;
            q_pop_ack = vt[i].qack; q_pop_valid = vt[i].qvalid; q_pop_message = vt[i].qmsg;
            tick();
            chk($sformatf("vec%0d_ack", i), pop_ack, vt[i].e_ack);
            chk($sformatf("vec%0d_qreq", i), q_pop_request, vt[i].e_qreq);
            if (vt[i].e_qreq) chk($sformatf("vec%0d_id", i), q_pop_chip_id, vt[i].e_id);
            chk($sformatf("vec%0d_valid", i), pop_valid, vt[i].e_valid);
            chk($sformatf("vec%0d_msg", i), pop_message, vt[i].e_msg);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
            chk($sformatf("vec%0d_tcnt", i), timeout_count, 16'd0);
        end
        q_pop_ack = 1'b0;

        // Round robin with all chains requesting; queue acks in one cycle.
        do_reset();
        pop_request = 4'hF;
        for (int t = 0; t < 5; t++) begin
            ok = 1'b0;
            for (int c = 0; c < 20 && !ok; c++) begin
                tick();
                chk("rr_onehot", $countones(pop_ack) <= 1, 1);
                if (q_pop_request) ok = 1'b1;
            end
            chk("rr_qreq_seen", ok, 1);
            chk("rr_id", q_pop_chip_id, pop_chip_id[(t % N)*8 +: 8]);
            q_pop_ack = 1'b1; q_pop_valid = 1'b1; q_pop_message = 32'(t);
            tick();
            q_pop_ack = 1'b0;
            chk($sformatf("rr_grant%0d", t), pop_ack, 4'b0001 << (t % N));
            chk("rr_msg", pop_message, 32'(t));
            pop_request = 4'hF & ~pop_ack;
            tick();
            chk("rr_release", pop_ack, 4'h0);
            pop_request = 4'hF;
        end
        pop_request = 4'h0;
        tick();

        // Timeout: queue never acks, then a stray late ack must change nothing.
        do_reset();
        pop_request = 4'h1;
        tick();
        chk("to_grant", q_pop_request, 1);
        n = 0;
        while (q_pop_request && n < 40) begin
            n++;
            tick();
        end
        chk("to_issue_len", n, T);
        chk("to_ack", pop_ack, 4'h1);
        chk("to_valid", pop_valid, 0);
        chk("to_msg", pop_message, 32'h0);
        chk("to_count", timeout_count, 16'd1);
        tick();
        q_pop_ack = 1'b1; q_pop_valid = 1'b1; q_pop_message = 32'hFFFF_0000;
        tick();
        q_pop_ack = 1'b0;
        chk("late_ack_held", pop_ack, 4'h1);
        chk("late_valid", pop_valid, 0);
        chk("late_msg", pop_message, 32'h0);
        chk("late_count", timeout_count, 16'd1);
        chk("late_qreq", q_pop_request, 0);
        pop_request = 4'h0;
        tick();
        chk("to_release", pop_ack, 4'h0);
        chk("to_busy", busy, 0);

        // Abort: granted chain 1 drops mid-ISSUE; chain 3 goes next.
        pop_request = 4'b1010;
        tick();
        chk("ab_id", q_pop_chip_id, 8'h22);
        tick();
        pop_request = 4'b1000;
        tick();
        tick();
        q_pop_ack = 1'b1; q_pop_valid = 1'b1; q_pop_message = 32'hA5A5A5A5;
        tick();
        q_pop_ack = 1'b0;
        chk("ab_ack", pop_ack, 4'b0010);
        chk("ab_msg", pop_message, 32'hA5A5A5A5);
        tick();
        chk("ab_pulse", pop_ack, 4'h0);
        chk("ab_idle", busy, 0);
        tick();
        chk("ab_next_qreq", q_pop_request, 1);
        chk("ab_next_id", q_pop_chip_id, 8'h44);
        q_pop_ack = 1'b1; q_pop_valid = 1'b0;
        tick();
        q_pop_ack = 1'b0;
        chk("ab_next_ack", pop_ack, 4'b1000);
        pop_request = 4'h0;
        tick();

        // Reset in the middle of ISSUE.
        pop_request = 4'b0100;
        tick();
        chk("rs_qreq", q_pop_request, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_ack", pop_ack, 4'h0);
        chk("rs_qreq0", q_pop_request, 0);
        chk("rs_id", q_pop_chip_id, 8'h00);
        chk("rs_valid", pop_valid, 0);
        chk("rs_msg", pop_message, 32'h0);
        chk("rs_busy", busy, 0);
        chk("rs_tcnt", timeout_count, 16'd0);
        pop_request = 4'b0101;
        tick();
        chk("rs_first_id", q_pop_chip_id, 8'h11);
        q_pop_ack = 1'b1;
        tick();
        q_pop_ack = 1'b0;
        chk("rs_first_ack", pop_ack, 4'b0001);
        pop_request = 4'h0;
        tick();

        // Randomized chains and queue against the transaction model.
        do_reset();
        ptr = 0; in_tx = 0; hold = 0; g = 0; qcnt = 0; k = 0; end_len = 0;
        exp_valid = 0; exp_msg = '0; tcount = '0; resp_valid = 0; resp_msg = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            req_a = pop_request;
            id_a  = pop_chip_id;
            tick();
            if (!in_tx) begin
                if (req_a != 4'h0) begin
                    g = rr_pick(req_a, ptr);
                    in_tx = 1; hold = 0; qcnt = 1;
                    k = int'($urandom_range(1, T + 3));
                    end_len = (k <= T) ? k : T;
                    resp_valid = 1'($urandom);
                    resp_msg = $urandom;
                    chk("rnd_grant_qreq", q_pop_request, 1);
                    chk("rnd_grant_id", q_pop_chip_id, id_a[g*8 +: 8]);
                    chk("rnd_grant_ack", pop_ack, 4'h0);
                    chk("rnd_grant_busy", busy, 1);
                end else begin
                    chk("rnd_idle_qreq", q_pop_request, 0);
                    chk("rnd_idle_ack", pop_ack, 4'h0);
                    chk("rnd_idle_busy", busy, 0);
                end
            end else if (!hold) begin
                if (qcnt == end_len) begin
                    hold = 1;
                    if (k <= T) begin
                        exp_valid = resp_valid;
                        exp_msg = resp_msg;
                    end else begin
                        exp_valid = 0;
                        if (tcount != 16'hFFFF) tcount++;
                    end
                    chk("rnd_done_qreq", q_pop_request, 0);
                    chk("rnd_done_ack", pop_ack, 4'b0001 << g);
                    chk("rnd_done_busy", busy, 1);
                end else begin
                    qcnt++;
                    chk("rnd_wait_qreq", q_pop_request, 1);
                    chk("rnd_wait_ack", pop_ack, 4'h0);
                end
            end else begin
                if (!req_a[g]) begin
                    in_tx = 0; hold = 0;
                    ptr = (g + 1) % N;
                    chk("rnd_rel_ack", pop_ack, 4'h0);
                    chk("rnd_rel_busy", busy, 0);
                end else begin
                    chk("rnd_hold_ack", pop_ack, 4'b0001 << g);
                end
            end
            chk("rnd_valid", pop_valid, exp_valid);
            chk("rnd_msg", pop_message, exp_msg);
            chk("rnd_tcnt", timeout_count, tcount);

            q_pop_ack = 1'b0;
            q_pop_valid = 1'($urandom);
            q_pop_message = $urandom;
            if (in_tx && !hold && qcnt == k) begin
                q_pop_ack = 1'b1; q_pop_valid = resp_valid; q_pop_message = resp_msg;
            end else if (!(in_tx && !hold) && $urandom_range(0, 7) == 0) begin
                q_pop_ack = 1'b1;
            end

            for (int i = 0; i < N; i++) begin
                if (pop_request[i]) begin
                    if (pop_ack[i] && $urandom_range(0, 1) == 1) pop_request[i] = 1'b0;
                    else if (in_tx && !hold && g == i && $urandom_range(0, 15) == 0) pop_request[i] = 1'b0;
                end else if (!(in_tx && g == i) && !pop_ack[i] && $urandom_range(0, 2) == 0) begin
                    pop_request[i] = 1'b1;
                    pop_chip_id[i*8 +: 8] = 8'($urandom);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
